spi_word_rx: RTL and testbench
==============================

Name: spi_word_rx

Overview:
- SPI slave receiver for the 24-bit command word emitted by the team's SPI word transmitter: 2'b01 header, 16-bit value, 6 zero pad bits.
- Oversamples `sck`/`mosi`/`csn` in the `clk` domain and assembles one frame per chip-select window.
- Checks framing and delivers the 16-bit value with a one-cycle valid strobe.
- Used for board-to-board loopback checks of the DAC driver and as the host-side SPI command input.

Parameters:
- WORD_BITS, 24, frame length in bits.
- SYNC_STAGES, 2, synchronizer flops on `sck`, `mosi`, `csn` (minimum 2).
- HEADER, 2'b01, required value of frame bits [23:22].

Ports:
- clk  input  1  system clock (40 MHz).
- resetn  input  1  synchronous, active-low reset.
- sck  input  1  SPI clock, asynchronous; idles low (mode 0).
- mosi  input  1  SPI data in, MSB first.
- csn  input  1  chip select, active low, asynchronous.
- miso  output  1  SPI data out (see Optional Feature).
- value_o  output  16  last good value, frame bits [21:6].
- valid_o  output  1  one-cycle strobe: `value_o` updated.
- err_o  output  1  one-cycle strobe: frame rejected.
- err_code_o  output  2  reason for the last rejection: 0 short, 1 long, 2 header, 3 pad nonzero.
- busy_o  output  1  high while in the SHIFT state.

Behaviour:
- Reset values:
  - `value_o` = 0, `valid_o` = 0, `err_o` = 0, `err_code_o` = 0, `busy_o` = 0, `miso` = 0.
  - Shift register 0, bit counter 0, state ARM.
- Synchronization and edge detection:
  - Each input passes through SYNC_STAGES flops, plus one history flop for edge detection.
  - `sck_rise` = synced `sck` 0->1; `csn_fall` / `csn_rise` defined likewise on synced `csn`.
- Data sampling:
  - `mosi` is sampled from the synced stage aligned with `sck`, on `sck_rise`.
  - Supported `sck` frequency is up to clk/4; faster is undefined.
- FSM states:
  - ARM: wait for synced `csn` = 1, then go to IDLE. This prevents accepting a partial frame after reset mid-transfer.
  - IDLE: on `csn_fall`, clear the shift register and bit counter, then go to SHIFT.
  - SHIFT: on `sck_rise`, shift in, `sr <= {sr[WORD_BITS-2:0], mosi}`.
  - SHIFT bit counter: increments and saturates at WORD_BITS+1, giving an overrun indication.
  - SHIFT exit: on `csn_rise`, go to CHECK.
  - CHECK (one cycle), evaluated in priority order:
    - count < WORD_BITS: err, code 0.
    - count > WORD_BITS: err, code 1.
    - header != HEADER: err, code 2.
    - pad != 0: err, code 3.
    - Otherwise: `value_o <= sr[21:6]` and `valid_o` = 1.
  - CHECK always returns to IDLE.
- Latency: `valid_o` / `err_o` assert SYNC_STAGES+2 clk cycles after the raw `csn` rising edge.
- `value_o` is held between good frames; a rejected frame never modifies it.
- Simultaneous `csn_rise` and `sck_rise` in the same cycle: `csn_rise` wins and the `sck` edge is discarded.
- A `csn_fall` during CHECK is impossible (a `csn` low pulse is at least 2 clk wide by spec); if it occurs, it is ignored.
- `resetn` low mid-frame: all outputs go to their reset values and the state goes to ARM.
- `busy_o` = (state == SHIFT).

Optional Feature:
- Macro: SPIRX_MISO_ECHO_EN.
- Defined:
  - On `csn_fall`, a 24-bit transmit register loads {HEADER, `value_o`, 6'b0}.
  - `miso` drives its MSB; the register shifts left on each synced `sck` falling edge within SHIFT.
  - `miso` = 0 outside SHIFT.
  - The host reads back the previously accepted word.
- Undefined: `miso` is constant 0 and no transmit register exists.

Decomposition:
- Package `spi_word_pkg`:
  - WORD_BITS, HEADER, PAD_BITS (6), VALUE_MSB/LSB (21/6).
  - Error code constants ERR_SHORT, ERR_LONG, ERR_HDR, ERR_PAD.
  - The state enum.
- Sub-module `sync_edge`:
  - Parameterized SYNC_STAGES synchronizer with registered rise/fall outputs.
  - Instantiated three times.

Test Plan:
- Reset, then frame 0x4D5140 (value 0x3545) at sck = clk/8 -> `valid_o` pulses once, `value_o` = 0x3545, `err_o` = 0, latency SYNC_STAGES+2 from `csn` rise.
- 23-bit frame -> `err_o` pulse, `err_code_o` = 0, `value_o` keeps 0x3545. 25-bit frame -> `err_code_o` = 1.
- Frame 0xCD5140 (header 2'b11) -> `err_code_o` = 2. Frame 0x4D5141 -> `err_code_o` = 3.
- Assert `resetn` low after bit 10 of a frame and release with `csn` still low, finish that frame, then send a good 0x400040 -> no strobe for the broken frame; valid with `value_o` = 0x0001 for the next frame.
- Back-to-back frames with a 2-clk `csn` high gap (values 0xFFFF then 0x0000) -> two valid pulses in order, correct values.
- With SPIRX_MISO_ECHO_EN: after accepting 0x3545, the next frame's `miso` bitstream = 0x4D5140 MSB first. Without the macro, `miso` is constantly 0.

Source files
------------

// File: rtl/spi_word_rx_pkg.sv
// Shared constants, error codes and FSM state encoding for the SPI command-word receiver.
package spi_word_pkg;

  localparam int WORD_BITS  = 24;
  localparam int PAD_BITS   = 6;
  localparam int VALUE_MSB  = 21;
  localparam int VALUE_LSB  = 6;
  localparam int VALUE_BITS = VALUE_MSB - VALUE_LSB + 1;

  localparam logic [1:0] HEADER = 2'b01;

  localparam logic [1:0] ERR_SHORT = 2'd0;
  localparam logic [1:0] ERR_LONG  = 2'd1;
  localparam logic [1:0] ERR_HDR   = 2'd2;
  localparam logic [1:0] ERR_PAD   = 2'd3;

  typedef logic [1:0] state_t;
  localparam state_t ST_ARM   = 2'd0;
  localparam state_t ST_IDLE  = 2'd1;
  localparam state_t ST_SHIFT = 2'd2;
  localparam state_t ST_CHECK = 2'd3;

endpackage

// File: rtl/spi_word_rx_if.sv
// SPI pins plus the received-word result bus of spi_word_rx.
interface spi_word_rx_if;
  import spi_word_pkg::*;

  logic                  sck;
  logic                  mosi;
  logic                  csn;
  logic                  miso;
  logic [VALUE_BITS-1:0] value_o;
  logic                  valid_o;
  logic                  err_o;
  logic [1:0]            err_code_o;
  logic                  busy_o;

  modport slave (
    input  sck, mosi, csn,
    output miso, value_o, valid_o, err_o, err_code_o, busy_o
  );

  modport master (
    output sck, mosi, csn,
    input  miso, value_o, valid_o, err_o, err_code_o, busy_o
  );

endinterface

// File: rtl/spi_word_rx_sync_edge.sv
// Multi-flop synchronizer with a history flop; rise/fall are decoded from flops only.
module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic i_d,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_stages;
  logic                   r_hist;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_stages <= '0;
      r_hist   <= 1'b0;
    end else begin
      r_stages <= {r_stages[SYNC_STAGES-2:0], i_d};
      r_hist   <= r_stages[SYNC_STAGES-1];
    end
  end

  assign o_level = r_stages[SYNC_STAGES-1];
  assign o_rise  = r_stages[SYNC_STAGES-1] & ~r_hist;
  assign o_fall  = ~r_stages[SYNC_STAGES-1] & r_hist;

endmodule

// File: rtl/spi_word_rx.sv
// SPI mode-0 slave receiving one 24-bit command word per chip-select window.
// Define SPIRX_MISO_ECHO_EN to echo the last accepted word on miso.
import spi_word_pkg::*;

module spi_word_rx #(
  parameter int         WORD_BITS   = spi_word_pkg::WORD_BITS,
  parameter int         SYNC_STAGES = 2,
  parameter logic [1:0] HEADER      = spi_word_pkg::HEADER
) (
  input  logic         clk,
  input  logic         resetn,
  spi_word_rx_if.slave bus
);

  localparam int CNT_W = $clog2(WORD_BITS + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORD_BITS);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WORD_BITS + 1);

  logic w_sckLevel, w_sckRise, w_sckFall;
  logic w_mosi, w_mosiRise, w_mosiFall;
  logic w_csnLevel, w_csnRise, w_csnFall;
  logic [2:0] w_unusedEdges;

  state_t                r_state;
  logic [WORD_BITS-1:0]  r_sr;
  logic [CNT_W-1:0]      r_cnt;
  logic [VALUE_BITS-1:0] r_value;
  logic                  r_valid;
  logic                  r_err;
  logic [1:0]            r_errCode;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sckSync (
    .clk(clk), .resetn(resetn), .i_d(bus.sck),
    .o_level(w_sckLevel), .o_rise(w_sckRise), .o_fall(w_sckFall)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_mosiSync (
    .clk(clk), .resetn(resetn), .i_d(bus.mosi),
    .o_level(w_mosi), .o_rise(w_mosiRise), .o_fall(w_mosiFall)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_csnSync (
    .clk(clk), .resetn(resetn), .i_d(bus.csn),
    .o_level(w_csnLevel), .o_rise(w_csnRise), .o_fall(w_csnFall)
  );

  assign w_unusedEdges = {w_sckLevel, w_mosiRise, w_mosiFall};

  // csn_rise is tested before sck_rise so a coincident clock edge is dropped.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state   <= ST_ARM;
      r_sr      <= '0;
      r_cnt     <= '0;
      r_value   <= '0;
      r_valid   <= 1'b0;
      r_err     <= 1'b0;
      r_errCode <= ERR_SHORT;
    end else begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        ST_ARM: begin
          if (w_csnLevel) r_state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (w_csnFall) begin
            r_sr    <= '0;
            r_cnt   <= '0;
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (w_csnRise) begin
            r_state <= ST_CHECK;
          end else if (w_sckRise) begin
            r_sr <= {r_sr[WORD_BITS-2:0], w_mosi};
            if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_CHECK: begin
          r_state <= ST_IDLE;
          if (r_cnt < CNT_FULL) begin
            r_err     <= 1'b1;
            r_errCode <= ERR_SHORT;
          end else if (r_cnt > CNT_FULL) begin
            r_err     <= 1'b1;
            r_errCode <= ERR_LONG;
          end else if (r_sr[WORD_BITS-1 -: 2] != HEADER) begin
            r_err     <= 1'b1;
            r_errCode <= ERR_HDR;
          end else if (r_sr[PAD_BITS-1:0] != '0) begin
            r_err     <= 1'b1;
            r_errCode <= ERR_PAD;
          end else begin
            r_value <= r_sr[VALUE_MSB:VALUE_LSB];
            r_valid <= 1'b1;
          end
        end
        default: r_state <= ST_ARM;
      endcase
    end
  end

`ifdef SPIRX_MISO_ECHO_EN
  logic [WORD_BITS-1:0] r_tx;

  // Loaded at frame start so the host reads back the previously accepted word.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_tx <= '0;
    end else if (r_state == ST_IDLE && w_csnFall) begin
      r_tx <= {HEADER, r_value, {PAD_BITS{1'b0}}};
    end else if (r_state == ST_SHIFT && w_sckFall) begin
      r_tx <= {r_tx[WORD_BITS-2:0], 1'b0};
    end
  end

  assign bus.miso = (r_state == ST_SHIFT) & r_tx[WORD_BITS-1];
`else
  logic w_unusedSckFall;
  assign w_unusedSckFall = w_sckFall;
  assign bus.miso        = 1'b0;
`endif

  assign bus.value_o    = r_value;
  assign bus.valid_o    = r_valid;
  assign bus.err_o      = r_err;
  assign bus.err_code_o = r_errCode;
  assign bus.busy_o     = (r_state == ST_SHIFT);

endmodule

// File: tb/tb_spi_word_rx.sv
// Directed bench for spi_word_rx: framing errors, reset mid-frame, back-to-back frames, miso echo.
module tb_spi_word_rx;

  localparam int HALF = 4;

  logic clk;
  logic resetn;
  int   total;
  int   bad;
  int   validCount;
  int   errCount;
  logic misoHigh;
  logic [31:0] misoWord;
  logic [15:0] validValues[$];

  spi_word_rx_if bus ();

  spi_word_rx dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe monitor: counts pulses and records each accepted value.
  always @(negedge clk) begin
    if (bus.valid_o === 1'b1) begin
      validCount <= validCount + 1;
      validValues.push_back(bus.value_o);
    end
    if (bus.err_o === 1'b1) errCount <= errCount + 1;
    if (bus.miso !== 1'b0) misoHigh <= 1'b1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clkWait(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic shiftBit(input logic b);
    bus.mosi = b;
    clkWait(HALF);
    misoWord = {misoWord[30:0], bus.miso};
    bus.sck = 1'b1;
    clkWait(HALF);
    bus.sck = 1'b0;
  endtask

  task automatic applyStimulus(input logic [31:0] frame, input int nBits, input int gapAfter);
    bus.csn  = 1'b0;
    misoWord = '0;
    clkWait(8);
    for (int i = nBits - 1; i >= 0; i--) shiftBit(frame[i]);
    clkWait(HALF);
    bus.csn = 1'b1;
    clkWait(gapAfter);
  endtask

  initial begin
    int v0;
    int e0;
    int lat;
    logic [31:0] brk;

    total      = 0;
    bad        = 0;
    validCount = 0;
    errCount   = 0;
    misoHigh   = 1'b0;
    misoWord   = '0;
    resetn     = 1'b0;
    bus.csn    = 1'b1;
    bus.sck    = 1'b0;
    bus.mosi   = 1'b0;
    clkWait(4);

    checkOutput("reset_value", 32'(bus.value_o), 32'h0);
    checkOutput("reset_valid", 32'(bus.valid_o), 32'h0);
    checkOutput("reset_err", 32'(bus.err_o), 32'h0);
    checkOutput("reset_code", 32'(bus.err_code_o), 32'h0);
    checkOutput("reset_busy", 32'(bus.busy_o), 32'h0);
    checkOutput("reset_miso", 32'(bus.miso), 32'h0);

    resetn = 1'b1;
    clkWait(6);

    // Good frame with latency measured from the raw csn rise
    v0 = validCount; e0 = errCount;
    applyStimulus(32'h4D5140, 24, 0);
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (bus.valid_o === 1'b1 && lat == 0) lat = k;
    end
    clkWait(6);
    checkOutput("good_latency", 32'(lat), 32'd4);
    checkOutput("good_valid_cnt", 32'(validCount - v0), 32'd1);
    checkOutput("good_err_cnt", 32'(errCount - e0), 32'd0);
    checkOutput("good_value", 32'(bus.value_o), 32'h3545);
    checkOutput("good_busy_idle", 32'(bus.busy_o), 32'h0);

    // Second good frame: echo must return the first accepted word
    v0 = validCount;
    applyStimulus(32'h4D5140, 24, 12);
    checkOutput("echo_valid_cnt", 32'(validCount - v0), 32'd1);
`ifdef SPIRX_MISO_ECHO_EN
    checkOutput("echo_miso_word", misoWord, 32'h4D5140);
`else
    checkOutput("miso_const_zero", 32'(misoHigh), 32'h0);
`endif

    // Framing errors, ordered so each error code differs from the previous one
    v0 = validCount; e0 = errCount;
    applyStimulus(32'hCD5140, 24, 12);
    checkOutput("hdr_err_cnt", 32'(errCount - e0), 32'd1);
    checkOutput("hdr_code", 32'(bus.err_code_o), 32'd2);
    checkOutput("hdr_value_kept", 32'(bus.value_o), 32'h3545);

    e0 = errCount;
    applyStimulus(32'h4D5141, 24, 12);
    checkOutput("pad_err_cnt", 32'(errCount - e0), 32'd1);
    checkOutput("pad_code", 32'(bus.err_code_o), 32'd3);
    checkOutput("pad_value_kept", 32'(bus.value_o), 32'h3545);

    e0 = errCount;
    applyStimulus(32'h26A8A0, 23, 12);
    checkOutput("short_err_cnt", 32'(errCount - e0), 32'd1);
    checkOutput("short_code", 32'(bus.err_code_o), 32'd0);
    checkOutput("short_value_kept", 32'(bus.value_o), 32'h3545);

    e0 = errCount;
    applyStimulus(32'h09AA280, 25, 12);
    checkOutput("long_err_cnt", 32'(errCount - e0), 32'd1);
    checkOutput("long_code", 32'(bus.err_code_o), 32'd1);
    checkOutput("errs_no_valid", 32'(validCount - v0), 32'd0);

    // Reset after bit 10 with csn held low; the broken frame must be ignored
    v0 = validCount; e0 = errCount;
    brk = 32'h4D5140;
    bus.csn = 1'b0;
    clkWait(8);
    for (int i = 23; i >= 13; i--) shiftBit(brk[i]);
    checkOutput("mid_busy", 32'(bus.busy_o), 32'h1);
    resetn = 1'b0;
    clkWait(3);
    checkOutput("mid_reset_value", 32'(bus.value_o), 32'h0);
    checkOutput("mid_reset_busy", 32'(bus.busy_o), 32'h0);
    resetn = 1'b1;
    for (int i = 12; i >= 0; i--) shiftBit(brk[i]);
    clkWait(HALF);
    bus.csn = 1'b1;
    clkWait(12);
    checkOutput("broken_no_strobe", 32'((validCount - v0) + (errCount - e0)), 32'd0);

    applyStimulus(32'h400040, 24, 12);
    checkOutput("after_reset_valid", 32'(validCount - v0), 32'd1);
    checkOutput("after_reset_value", 32'(bus.value_o), 32'h0001);

    // Back-to-back frames with a 2-clk csn high gap
    v0 = validCount; e0 = errCount;
    applyStimulus(32'h7FFFC0, 24, 2);
    applyStimulus(32'h400000, 24, 12);
    checkOutput("b2b_valid_cnt", 32'(validCount - v0), 32'd2);
    checkOutput("b2b_err_cnt", 32'(errCount - e0), 32'd0);
    if (validValues.size() >= 2) begin
      checkOutput("b2b_first", 32'(validValues[validValues.size()-2]), 32'hFFFF);
      checkOutput("b2b_second", 32'(validValues[validValues.size()-1]), 32'h0000);
    end else begin
      checkOutput("b2b_values_present", 32'(validValues.size()), 32'd2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
